// File: rtl/sseg_scan_arbiter.sv
// Four-digit common-anode 7-segment scan controller shared by a live source (A) and a timed override (B).
// Optional build macro SSEG_OWNER_DP_EN lights digit 3's decimal point while B owns the display.
module sseg_scan_arbiter #(
   parameter int SCAN_DIV    = 50000,
   parameter int HOLD_FRAMES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        a_req,
   input  logic [15:0] a_data,
   output logic        a_ack,
   input  logic        b_req,
   input  logic [15:0] b_data,
   output logic        b_ack,
   output logic [7:0]  sseg,
   output logic [3:0]  AN,
   output logic        owner,
   output logic        frame_tick
);

   localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int HW = $clog2(HOLD_FRAMES + 1);
   localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] PRESC_PRE = PW'(SCAN_DIV - 2);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_FRAMES);

   typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

   state_t        state, state_n;
   logic [PW-1:0] presc;
   logic [1:0]    digit, digit_n;
   logic [HW-1:0] hold, hold_n;
   logic [15:0]   disp_buf, buf_n;
   logic          a_ack_n, b_ack_n, owner_n, frame_tick_n;
   logic [3:0]    an_n;
   logic [7:0]    sseg_n;
   logic          digit_tick, frame_end;
   logic          take_a, take_b, go_idle;
   logic [3:0]    nib;
   logic          dp_n;

   assign digit_tick = (presc == PRESC_MAX);
   assign frame_end  = digit_tick && (digit == 2'd3);
   assign digit_n    = digit_tick ? digit + 2'd1 : digit;

   function automatic logic [6:0] seg_gfedcba(input logic [3:0] n);
      case (n)
         4'h0: seg_gfedcba = 7'h3F;
         4'h1: seg_gfedcba = 7'h06;
         4'h2: seg_gfedcba = 7'h5B;
         4'h3: seg_gfedcba = 7'h4F;
         4'h4: seg_gfedcba = 7'h66;
         4'h5: seg_gfedcba = 7'h6D;
         4'h6: seg_gfedcba = 7'h7D;
         4'h7: seg_gfedcba = 7'h07;
         4'h8: seg_gfedcba = 7'h7F;
         4'h9: seg_gfedcba = 7'h6F;
         4'hA: seg_gfedcba = 7'h77;
         4'hB: seg_gfedcba = 7'h7C;
         4'hC: seg_gfedcba = 7'h39;
         4'hD: seg_gfedcba = 7'h5E;
         4'hE: seg_gfedcba = 7'h79;
         default: seg_gfedcba = 7'h71;
      endcase
   endfunction

   // State register; every output is a flop loaded from its next-cycle value.
   always_ff @(posedge clk) begin
      if (!reset) begin
         presc      <= '0;
         digit      <= 2'd0;
         state      <= IDLE;
         hold       <= '0;
         disp_buf   <= 16'h0000;
         a_ack      <= 1'b0;
         b_ack      <= 1'b0;
         AN         <= 4'b1111;
         sseg       <= 8'hFF;
         owner      <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         presc      <= digit_tick ? '0 : presc + 1'b1;
         digit      <= digit_n;
         state      <= state_n;
         hold       <= hold_n;
         disp_buf   <= buf_n;
         a_ack      <= a_ack_n;
         b_ack      <= b_ack_n;
         AN         <= an_n;
         sseg       <= sseg_n;
         owner      <= owner_n;
         frame_tick <= frame_tick_n;
      end
   end

   // Arbitration decisions are taken only on the last cycle of a frame, so ownership never tears a scan.
   always_comb begin
      take_a  = 1'b0;
      take_b  = 1'b0;
      go_idle = 1'b0;
      state_n = state;
      hold_n  = hold;
      buf_n   = disp_buf;
      a_ack_n = 1'b0;
      b_ack_n = 1'b0;
      if (frame_end) begin
         case (state)
            IDLE, OWN_A: begin
               if (b_req)      take_b  = 1'b1;
               else if (a_req) take_a  = 1'b1;
               else            go_idle = 1'b1;
            end
            OWN_B: begin
               if (hold > HW'(1)) hold_n = hold - 1'b1;
               else if (a_req)    take_a  = 1'b1;
               else if (b_req)    take_b  = 1'b1;
               else               go_idle = 1'b1;
            end
            default: go_idle = 1'b1;
         endcase
         if (take_b) begin
            state_n = OWN_B;
            buf_n   = b_data;
            b_ack_n = 1'b1;
            hold_n  = HOLD_LOAD;
         end else if (take_a) begin
            state_n = OWN_A;
            buf_n   = a_data;
            a_ack_n = 1'b1;
            hold_n  = '0;
         end else if (go_idle) begin
            state_n = IDLE;
            hold_n  = '0;
         end
      end
   end

   always_comb begin
      owner_n      = (state_n == OWN_B);
      frame_tick_n = (presc == PRESC_PRE) && (digit == 2'd3);
      case (digit_n)
         2'd0:    nib = buf_n[3:0];
         2'd1:    nib = buf_n[7:4];
         2'd2:    nib = buf_n[11:8];
         default: nib = buf_n[15:12];
      endcase
`ifdef SSEG_OWNER_DP_EN
      dp_n = !(owner_n && (digit_n == 2'd3));
`else
      dp_n = 1'b1;
`endif
      if (state_n == IDLE) begin
         an_n   = 4'b1111;
         sseg_n = 8'hFF;
      end else begin
         an_n   = ~(4'b0001 << digit_n);
         sseg_n = {~seg_gfedcba(nib), dp_n};
      end
   end

endmodule

// File: tb/tb_sseg_scan_arbiter.sv
// Directed bench for sseg_scan_arbiter: acks are predicted into a queue and matched by a monitor.
module tb_sseg_scan_arbiter;

   localparam int W = 27;  // {cycle[15:0], b_ack, a_ack, owner, sseg[7:0]}
`ifdef SSEG_OWNER_DP_EN
   localparam logic DP3_B = 1'b0;
`else
   localparam logic DP3_B = 1'b1;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        a_req = 1'b0, b_req = 1'b0;
   logic [15:0] a_data = 16'h0000, b_data = 16'h0000;
   logic        a_ack, b_ack, owner, frame_tick;
   logic [7:0]  sseg;
   logic [3:0]  AN;

   logic [W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;

   sseg_scan_arbiter #(.SCAN_DIV(4), .HOLD_FRAMES(2)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_data(a_data), .a_ack(a_ack),
      .b_req(b_req), .b_data(b_data), .b_ack(b_ack),
      .sseg(sseg), .AN(AN), .owner(owner), .frame_tick(frame_tick)
   );

   // Clock and the bench's own cycle count since reset release.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= reset ? cyc + 1 : 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [W-1:0] ev(input int c, input logic b, input logic a,
                                        input logic o, input logic [7:0] s);
      ev = {c[15:0], b, a, o, s};
   endfunction

   // Advance to the posedge that makes cyc == c, then 1 time unit past it.
   task automatic to_cyc(input int c);
      int guard = 0;
      do begin
         @(posedge clk); #1;
         guard++;
      end while (cyc != c && guard < 400);
      if (cyc != c) chk("timeout", cyc, c);
   endtask

   task automatic disp_at(input int c, input logic [3:0] an_e, input logic [7:0] s_e);
      to_cyc(c);
      @(negedge clk);
      chk("an", {28'h0, AN}, {28'h0, an_e});
      chk("sseg", {24'h0, sseg}, {24'h0, s_e});
   endtask

   task automatic owner_at(input int c, input logic o_e);
      to_cyc(c);
      @(negedge clk);
      chk("owner", {31'h0, owner}, {31'h0, o_e});
   endtask

   // Monitor: frame_tick cadence every cycle, and every ack against the expected queue.
   always @(negedge clk) begin
      chk("frame_tick", {31'h0, frame_tick}, {31'h0, (cyc % 16) == 15});
      if (a_ack === 1'b1 || b_ack === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("ack_unexpected", {5'h0, cyc[15:0], b_ack, a_ack, owner, sseg}, 32'h0);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            chk("ack_event", {5'h0, cyc[15:0], b_ack, a_ack, owner, sseg}, {5'h0, e});
         end
      end
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_an", {28'h0, AN}, 32'hF);
      chk("rst_sseg", {24'h0, sseg}, 32'hFF);
      chk("rst_acks", {30'h0, a_ack, b_ack}, 32'h0);
      chk("rst_owner", {31'h0, owner}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b1;

      // Idle: blank display across a frame boundary
      disp_at(8, 4'b1111, 8'hFF);
      disp_at(17, 4'b1111, 8'hFF);

      // A alone, then mid-frame data change
      to_cyc(20);
      a_req = 1'b1; a_data = 16'h0001;
      exp_q.push_back(ev(32, 1'b0, 1'b1, 1'b0, 8'hF3));
      disp_at(33, 4'b1110, 8'hF3);
      to_cyc(34);
      a_data = 16'h0010;
      exp_q.push_back(ev(48, 1'b0, 1'b1, 1'b0, 8'h81));
      disp_at(37, 4'b1101, 8'h81);
      disp_at(41, 4'b1011, 8'h81);
      disp_at(45, 4'b0111, 8'h81);
      disp_at(53, 4'b1101, 8'hF3);
      to_cyc(54);
      a_req = 1'b0;
      disp_at(65, 4'b1111, 8'hFF);

      // Simultaneous requests from idle: B wins, holds 2 frames, A gets one frame, B again
      to_cyc(66);
      a_req = 1'b1; b_req = 1'b1; b_data = 16'h8A21;
      exp_q.push_back(ev(80, 1'b1, 1'b0, 1'b1, 8'hF3));
      exp_q.push_back(ev(112, 1'b0, 1'b1, 1'b0, 8'h81));
      exp_q.push_back(ev(128, 1'b1, 1'b0, 1'b1, 8'hF3));
      owner_at(79, 1'b0);
      owner_at(80, 1'b1);
      disp_at(81, 4'b1110, 8'hF3);
      disp_at(85, 4'b1101, 8'h49);
      disp_at(89, 4'b1011, 8'h11);
      disp_at(93, 4'b0111, {7'h00, DP3_B});
      owner_at(111, 1'b1);
      owner_at(112, 1'b0);
      disp_at(117, 4'b1101, 8'hF3);
      owner_at(127, 1'b0);
      owner_at(128, 1'b1);

      // Reset during the B hold discards it; B is regranted after release
      to_cyc(133);
      a_req = 1'b0;
      to_cyc(134);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_an", {28'h0, AN}, 32'hF);
      chk("midrst_sseg", {24'h0, sseg}, 32'hFF);
      chk("midrst_owner", {31'h0, owner}, 32'h0);
      chk("midrst_acks", {30'h0, a_ack, b_ack}, 32'h0);
      exp_q.push_back(ev(16, 1'b1, 1'b0, 1'b1, 8'hF3));
      @(posedge clk); #1;
      reset = 1'b1;
      owner_at(16, 1'b1);
      to_cyc(20);
      b_req = 1'b0;
      owner_at(47, 1'b1);
      owner_at(49, 1'b0);
      disp_at(50, 4'b1111, 8'hFF);
      to_cyc(60);

      chk("queue_empty", exp_q.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
